// File: rtl/pwm_capture.sv
// pwm_capture: measures an asynchronous PWM line and decodes speed from its high time.
//
// The line is synchronised, optionally glitch filtered, and edge detected. The FSM then
// counts the high time and the rising-to-rising period. Each rising edge that closes a
// full period publishes:
//    speed_out  = min(floor(high_cnt / 3), 199)
//    period_out = per_cnt (saturating at 1023)
// valid_out pulses for one cycle on every publish.
//
// A single down-counter measures the time since the last line transition. It is
// reloaded on every edge.
//    - Line low too long (LOW or WAIT_RISE): report idle. This publishes speed 0.
//    - Line high too long (HIGH): flag stuck-high and publish nothing.
// A rising edge that lands on the same cycle as the timeout wins over the timeout.
//
// Latency: a pwm_in rising edge sampled at clock edge N makes valid_out go high at
// edge N+SYNC_STAGES+1. A synchronous observer therefore first samples valid_out high
// at edge N+SYNC_STAGES+2. The path through the design is:
//    - SYNC_STAGES synchroniser flops
//    - a registered edge pulse
//    - the registered FSM outputs
//
// Build option PWM_CAPTURE_GLITCH_FILTER_EN inserts a filter after the synchroniser.
// The filter output follows the line only once 3 consecutive samples agree. This
// drops pulses of 2 clocks or less and delays both edges by 2 cycles.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WAIT_RISE | no measurement running; next rising edge starts one
// HIGH      | line high, counting high time and period
// LOW       | line low, high time frozen, counting period until next rise

module pwm_capture #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwm_in,
   output logic [7:0] speed_out,
   output logic [9:0] period_out,
   output logic       valid_out,
   output logic       idle_out,
   output logic       stuck_high_out
);

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      HIGH      = 2'd1,
      LOW       = 2'd2
   } state_t;

   localparam logic [9:0] CNT_MAX    = 10'd1023;
   localparam logic [9:0] TMO_RELOAD = 10'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0] SPEED_MAX  = 8'd199;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_line;
   logic                   line;
   logic                   line_d;
   logic                   rise_q;
   logic                   fall_q;

   state_t     state_q, state_n;
   logic [9:0] high_q, high_n;
   logic [9:0] per_q, per_n;
   logic [9:0] tmr_q, tmr_n;
   logic       done_q, done_n;
   logic       tmo_hit;

   logic [7:0] speed_n;
   logic [9:0] period_n;
   logic       valid_n;
   logic       idle_n;
   logic       stuck_n;

   logic [19:0] prod;
   logic [8:0]  quo;
   logic [7:0]  speed_calc;

   function automatic logic [9:0] sat_inc(input logic [9:0] v);
      return (v == CNT_MAX) ? v : v + 10'd1;
   endfunction

   // Synchroniser chain for the asynchronous PWM input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      end
   end

   // Last synchroniser stage is the raw resynchronised line.
   always_comb begin
      sync_line = sync_q[SYNC_STAGES-1];
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q;

   // Filtered line changes only once the current sample and the two before it agree.
   always_comb begin
      line = filt_q;
      if ((sync_line == hist_q[0]) && (hist_q[0] == hist_q[1])) begin
         line = sync_line;
      end
   end

   // Sample history and held filter output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], sync_line};
         filt_q <= line;
      end
   end
`else
   // Without the filter the measured line is the synchroniser output itself.
   always_comb begin
      line = sync_line;
   end
`endif

   // Edge detect against the one-cycle-delayed copy.
   // The edge pulses are registered so line_d is the level they refer to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_d <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         line_d <= line;
         rise_q <= line & ~line_d;
         fall_q <= ~line & line_d;
      end
   end

   // Divide by 3 as a multiply-shift; exact floor for every 10-bit high count.
   always_comb begin
      prod       = 20'(high_q) * 20'd683;
      quo        = 9'(prod >> 11);
      speed_calc = (quo > 9'd199) ? SPEED_MAX : quo[7:0];
   end

   // The timeout fires once per quiet stretch; an edge re-arms it.
   always_comb begin
      tmo_hit = (tmr_q == 10'd0) && !done_q;
   end

   // Next-state, counter and output logic.
   always_comb begin
      state_n  = state_q;
      high_n   = high_q;
      per_n    = per_q;
      tmr_n    = tmr_q;
      done_n   = done_q;
      speed_n  = speed_out;
      period_n = period_out;
      valid_n  = 1'b0;
      idle_n   = idle_out;
      stuck_n  = stuck_high_out;

      if (rise_q || fall_q) begin
         tmr_n  = TMO_RELOAD;
         done_n = 1'b0;
      end else if (tmr_q != 10'd0) begin
         tmr_n = tmr_q - 10'd1;
      end

      case (state_q)
         WAIT_RISE: begin
            if (rise_q) begin
               state_n = HIGH;
               high_n  = 10'd1;
               per_n   = 10'd1;
            end else if (fall_q) begin
               stuck_n = 1'b0;
            end else if (tmo_hit && !line_d) begin
               speed_n = 8'd0;
               valid_n = 1'b1;
               idle_n  = 1'b1;
               done_n  = 1'b1;
            end
         end
         HIGH: begin
            high_n = sat_inc(high_q);
            per_n  = sat_inc(per_q);
            if (fall_q) begin
               state_n = LOW;
               high_n  = high_q;
               stuck_n = 1'b0;
            end else if (tmo_hit) begin
               state_n = WAIT_RISE;
               stuck_n = 1'b1;
               done_n  = 1'b1;
            end
         end
         LOW: begin
            per_n = sat_inc(per_q);
            if (rise_q) begin
               speed_n  = speed_calc;
               period_n = per_q;
               valid_n  = 1'b1;
               idle_n   = 1'b0;
               stuck_n  = 1'b0;
               state_n  = HIGH;
               high_n   = 10'd1;
               per_n    = 10'd1;
            end else if (tmo_hit) begin
               speed_n = 8'd0;
               valid_n = 1'b1;
               idle_n  = 1'b1;
               done_n  = 1'b1;
               state_n = WAIT_RISE;
            end
         end
         default: begin
            state_n = WAIT_RISE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= WAIT_RISE;
         high_q         <= 10'd0;
         per_q          <= 10'd0;
         tmr_q          <= TMO_RELOAD;
         done_q         <= 1'b0;
         speed_out      <= 8'd0;
         period_out     <= 10'd0;
         valid_out      <= 1'b0;
         idle_out       <= 1'b0;
         stuck_high_out <= 1'b0;
      end else begin
         state_q        <= state_n;
         high_q         <= high_n;
         per_q          <= per_n;
         tmr_q          <= tmr_n;
         done_q         <= done_n;
         speed_out      <= speed_n;
         period_out     <= period_n;
         valid_out      <= valid_n;
         idle_out       <= idle_n;
         stuck_high_out <= stuck_n;
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture covering these cases:
//    - reset values
//    - nominal decode and latency
//    - speed extremes and period saturation
//    - idle timeout and stuck-high timeout
//    - rise/timeout tie
//    - reset mid-measurement
//    - short pulses
module tb_pwm_capture;

   localparam int SYNC = 2;
   localparam int TMO  = 1023;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   localparam int LAT  = SYNC + 4;
`else
   localparam int LAT  = SYNC + 2;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       pwm_in;
   logic [7:0] speed_out;
   logic [9:0] period_out;
   logic       valid_out;
   logic       idle_out;
   logic       stuck_high_out;

   int vectors        = 0;
   int miscompares    = 0;
   int cyc            = 0;
   int vcount         = 0;
   int last_valid_cyc = 0;
   int rise_cyc       = 0;
   int vbase          = 0;

   pwm_capture #(
      .SYNC_STAGES   (SYNC),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pwm_in        (pwm_in),
      .speed_out     (speed_out),
      .period_out    (period_out),
      .valid_out     (valid_out),
      .idle_out      (idle_out),
      .stuck_high_out(stuck_high_out)
   );

   always #5 clk = ~clk;

   // Edge counter; after edge k it reads k.
   always @(posedge clk) cyc <= cyc + 1;

   // Count valid pulses cycle by cycle and remember when the latest one appeared.
   always @(negedge clk) begin
      if (valid_out === 1'b1) begin
         vcount         <= vcount + 1;
         last_valid_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One PWM period: hi clocks high then low to the end of per.
   // It is called just after a rising clock edge, and each value is sampled exactly once.
   task automatic drive(input int hi, input int per);
      for (int i = 0; i < per; i++) begin
         pwm_in = (i < hi);
         if (i == 0) rise_cyc = cyc + 1;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst    = 1'b1;
      pwm_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_speed",  speed_out,      0);
      check("rst_period", period_out,     0);
      check("rst_valid",  valid_out,      0);
      check("rst_idle",   idle_out,       0);
      check("rst_stuck",  stuck_high_out, 0);
      rst = 1'b0;

      // Nominal 300/607: the first rise only starts, later rises publish.
      repeat (3) drive(300, 607);
      check("a_count",   vcount, 2);
      check("a_speed",   speed_out, 100);
      check("a_period",  period_out, 607);
      check("a_latency", last_valid_cyc + 1 - rise_cyc, LAT);
      check("a_idle",    idle_out, 0);
      check("a_stuck",   stuck_high_out, 0);

      // Each drive's opening rise publishes the previous period.
      vbase = vcount;
      drive(597, 607);
      check("b_speed_300",   speed_out, 100);
      check("b_period_300",  period_out, 607);
      drive(3, 607);
      check("b_speed_597",   speed_out, 199);
      check("b_period_597",  period_out, 607);
      drive(1020, 1100);
      check("b_speed_3",     speed_out, 1);
      check("b_period_3",    period_out, 607);
      drive(300, 607);
      check("b_speed_1020",  speed_out, 199);
      check("b_period_sat",  period_out, 1023);
      check("b_count",       vcount - vbase, 4);

      // Long low after a measurement: one idle publish with speed 0.
      vbase = vcount;
      drive(0, 1100);
      check("c_count",  vcount - vbase, 1);
      check("c_speed",  speed_out, 0);
      check("c_idle",   idle_out, 1);
      check("c_period", period_out, 1023);

      // The first rise after idle starts a measurement only; the next one publishes.
      vbase = vcount;
      drive(300, 607);
      check("c2_count0", vcount - vbase, 0);
      check("c2_idle0",  idle_out, 1);
      drive(300, 607);
      check("c2_count1", vcount - vbase, 1);
      check("c2_speed",  speed_out, 100);
      check("c2_period", period_out, 607);
      check("c2_idle1",  idle_out, 0);

      // Stuck high: flag set, no extra publish, speed held; a falling edge clears it.
      vbase = vcount;
      drive(1200, 1200);
      check("d_count",  vcount - vbase, 1);
      check("d_stuck",  stuck_high_out, 1);
      check("d_speed",  speed_out, 100);
      check("d_period", period_out, 607);
      drive(0, 20);
      check("d_stuck_clr", stuck_high_out, 0);
      check("d_count2",    vcount - vbase, 1);
      check("d_idle",      idle_out, 0);

      // Low for exactly the timeout, then a rise: the rise wins and publishes normally.
      vbase = vcount;
      drive(300, 300 + TMO);
      check("d2_count0", vcount - vbase, 0);
      drive(300, 607);
      check("d2_count1", vcount - vbase, 1);
      check("d2_speed",  speed_out, 100);
      check("d2_period", period_out, 1023);
      check("d2_idle",   idle_out, 0);

      // Reset in the middle of a high phase discards the partial measurement.
      drive(100, 100);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("e_rst_speed",  speed_out, 0);
      check("e_rst_period", period_out, 0);
      check("e_rst_valid",  valid_out, 0);
      pwm_in = 1'b0;
      rst    = 1'b0;
      vbase  = vcount;
      drive(150, 607);
      drive(150, 607);
      check("e_count",  vcount - vbase, 1);
      check("e_speed",  speed_out, 50);
      check("e_period", period_out, 607);

      // 2-clock pulses: speed 0 without the filter; invisible (so idle) with it.
      vbase = vcount;
      drive(2, 607);
      drive(2, 607);
      check("f_speed",  speed_out, 0);
      check("f_period", period_out, 607);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      check("f_count",  vcount - vbase, 1);
      check("f_idle",   idle_out, 1);
`else
      check("f_count",  vcount - vbase, 2);
      check("f_idle",   idle_out, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
